socket_frame_collector: RTL

//  Downstream neighbour of the socket FIFO read controller. Observes the controller's

---
 rtl/socket_pkg.sv | 12 +
 rtl/socket_dv_delay.sv | 27 ++
 rtl/socket_frame_collector.sv | 110 +++++++++++
 3 files changed

// File: rtl/socket_pkg.sv
// Shared types and constants for the socket frame collector slice.
package socket_pkg;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } t_collect_state;

  localparam int unsigned RD_LATENCY_MAX = 3;
  localparam int unsigned FRAME_CNT_W    = 16;

endpackage

// File: rtl/socket_dv_delay.sv
// Delays the FIFO read enable by the FIFO read latency to form the word-valid strobe.
module socket_dv_delay #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rd_en,
  output logic o_wv
);

  logic [RD_LATENCY-1:0] dv_q;

  if (RD_LATENCY == 1) begin : g_single
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) dv_q <= '0;
      else          dv_q <= i_rd_en;
    end
  end else begin : g_chain
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) dv_q <= '0;
      else          dv_q <= {dv_q[RD_LATENCY-2:0], i_rd_en};
    end
  end

  assign o_wv = dv_q[RD_LATENCY-1];

endmodule

// File: rtl/socket_frame_collector.sv
// Packs FRAME_LEN latency-qualified FIFO words into a frame and hands it downstream
// over valid/ready, with one extra buffer so collection overlaps a stalled handoff.
module socket_frame_collector
  import socket_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FRAME_LEN  = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_rd_en,
  input  logic [DATA_WIDTH-1:0]            i_data,
  input  logic                             i_frame_ready,
  output logic [DATA_WIDTH*FRAME_LEN-1:0]  o_frame,
  output logic                             o_frame_valid,
  output logic                             o_busy,
  output logic                             o_overflow,
  output logic [FRAME_CNT_W-1:0]           o_frame_cnt
);

  localparam int unsigned     IDX_W    = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  t_collect_state state_q, state_d;

  logic                                wv;
  logic [FRAME_LEN-1:0][DATA_WIDTH-1:0] coll_q;
  logic [FRAME_LEN-1:0][DATA_WIDTH-1:0] coll_live_c;
  logic [IDX_W-1:0]                    idx_q;
  logic                                store_word;
  logic                                load_live;
  logic                                load_held;
  logic                                drop_word;
  logic                                consume;

  socket_dv_delay #(
    .RD_LATENCY (RD_LATENCY)
  ) u_dv_delay (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_rd_en (i_rd_en),
    .o_wv    (wv)
  );

  assign consume = o_frame_valid && i_frame_ready;

  // Collect buffer as it looks once the word arriving this cycle is included.
  always_comb begin
    coll_live_c        = coll_q;
    coll_live_c[idx_q] = i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_COLLECT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    store_word = 1'b0;
    load_live  = 1'b0;
    load_held  = 1'b0;
    drop_word  = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (wv) begin
          store_word = 1'b1;
          if (idx_q == IDX_LAST) begin
            if (!o_frame_valid || i_frame_ready) load_live = 1'b1;
            else                                 state_d   = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        drop_word = wv;
        if (i_frame_ready) begin
          load_held = 1'b1;
          state_d   = ST_COLLECT;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      coll_q        <= '0;
      idx_q         <= '0;
      o_frame       <= '0;
      o_frame_valid <= 1'b0;
      o_busy        <= 1'b0;
      o_overflow    <= 1'b0;
      o_frame_cnt   <= '0;
    end else begin
      if (store_word) begin
        coll_q[idx_q] <= i_data;
        idx_q         <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
      if (load_live)      o_frame <= coll_live_c;
      else if (load_held) o_frame <= coll_q;
      // A reload in the handoff cycle keeps valid high without a bubble.
      if (load_live || load_held) o_frame_valid <= 1'b1;
      else if (consume)           o_frame_valid <= 1'b0;
      o_busy <= (state_d == ST_HOLD);
      if (drop_word) o_overflow <= 1'b1;
      if (consume)   o_frame_cnt <= o_frame_cnt + FRAME_CNT_W'(1);
    end
  end

endmodule
